writeback_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register; forms the writeback stage of the 5-stage MIPS core.
- Selects the result from three sources: ALU result, load data with byte/halfword extraction, or link address.
- Commits the result to the 32x32 architectural register file, which it owns.
- Serves the decode stage's two combinational read ports with internal write-through bypass, and keeps a retired-write counter for performance debug.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/load_extract.sv | 37 +++
 rtl/writeback_regfile.sv | 108 ++++++++++
 tb/tb_writeback_regfile.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: load-size encodings and fixed register numbers.
package mips_pkg;

    localparam logic [1:0] BC_WORD   = 2'b00;
    localparam logic [1:0] BC_HALF_S = 2'b01;
    localparam logic [1:0] BC_BYTE_S = 2'b10;
    localparam logic [1:0] BC_BYTE_U = 2'b11;

    localparam int LINK_REG = 31;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LOAD = 2'b01,
        SRC_LINK = 2'b10
    } wb_src_e;

    // Link beats load, load beats ALU.
    function automatic wb_src_e wb_src_sel(input logic link, input logic mem_to_reg);
        if (link)
            return SRC_LINK;
        else if (mem_to_reg)
            return SRC_LOAD;
        else
            return SRC_ALU;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian load lane selection with sign/zero extension.
module load_extract
    import mips_pkg::*;
#(
    parameter int WIDTH_32 = 32
) (
    input  logic [1:0]          byte_control,
    input  logic [1:0]          byte_addr,
    input  logic [WIDTH_32-1:0] read_data,
    output logic [WIDTH_32-1:0] load_data
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = read_data[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = byte_lane[byte_addr];
    assign half_sel = byte_addr[1] ? read_data[31:16] : read_data[15:0];

    always_comb begin
        load_data = read_data;
        case (byte_control)
            BC_WORD:   load_data = read_data;
            BC_HALF_S: load_data = {{(WIDTH_32-16){half_sel[15]}}, half_sel};
            BC_BYTE_S: load_data = {{(WIDTH_32-8){byte_sel[7]}}, byte_sel};
            BC_BYTE_U: load_data = {{(WIDTH_32-8){1'b0}}, byte_sel};
            default:   load_data = read_data;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, 32x32 register file with write-through
// bypass on two read ports, and a retired-write counter.
module writeback_regfile #(
    parameter int WIDTH_5  = 5,
    parameter int WIDTH_32 = 32,
    parameter int LINK_REG = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RegWrite_W,
    input  logic                MemtoReg_W,
    input  logic                link_W,
    input  logic                J_W,
    input  logic                Jr_W,
    input  logic [1:0]          ByteControl_W,
    input  logic [WIDTH_32-1:0] ALU_result_W,
    input  logic [WIDTH_32-1:0] ReadData_W,
    input  logic [WIDTH_5-1:0]  WriteReg_W,
    input  logic [WIDTH_32-1:0] PC_plus_4_W,
    input  logic                Retire_W,
    input  logic [WIDTH_5-1:0]  A1,
    input  logic [WIDTH_5-1:0]  A2,
    output logic [WIDTH_32-1:0] RD1,
    output logic [WIDTH_32-1:0] RD2,
    output logic [WIDTH_32-1:0] Result_W,
    output logic [WIDTH_5-1:0]  WriteRegEff_W,
    output logic [WIDTH_32-1:0] wr_count
);
    import mips_pkg::*;

    localparam int NUM_REGS = 1 << WIDTH_5;

    logic [WIDTH_32-1:0] regs_reg [NUM_REGS];
    logic [WIDTH_32-1:0] wr_count_reg;
    logic [WIDTH_32-1:0] load_data;
    logic                we;
    logic                jump_no_link;
    logic                count_en;
    wb_src_e             src_sel;

    load_extract #(
        .WIDTH_32 (WIDTH_32)
    ) u_load_extract (
        .byte_control (ByteControl_W),
        .byte_addr    (ALU_result_W[1:0]),
        .read_data    (ReadData_W),
        .load_data    (load_data)
    );

    assign src_sel = wb_src_sel(link_W, MemtoReg_W);

    always_comb begin
        Result_W = ALU_result_W;
        case (src_sel)
            SRC_LINK: Result_W = PC_plus_4_W;
            SRC_LOAD: Result_W = load_data;
            default:  Result_W = ALU_result_W;
        endcase
    end

    assign WriteRegEff_W = link_W ? WIDTH_5'(LINK_REG) : WriteReg_W;
    assign we            = RegWrite_W && (WriteRegEff_W != WIDTH_5'(REG_ZERO));

    // A plain jump carries no RegWrite, so it can never reach the counter.
    assign jump_no_link = (J_W | Jr_W) & ~link_W;
    assign count_en     = we & Retire_W & (~jump_no_link | RegWrite_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_reg[i] <= '0;
        end else if (we) begin
            regs_reg[WriteRegEff_W] <= Result_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            wr_count_reg <= '0;
        else if (count_en)
            wr_count_reg <= wr_count_reg + 1'b1;
    end

    assign wr_count = wr_count_reg;

    logic [WIDTH_5-1:0]  rd_addr [2];
    logic [WIDTH_32-1:0] rd_data [2];

    assign rd_addr[0] = A1;
    assign rd_addr[1] = A2;

    // Reset forces reads to zero so nothing from the old architectural state leaks.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                rd_data[gi] = regs_reg[rd_addr[gi]];
                if (rst || rd_addr[gi] == WIDTH_5'(REG_ZERO))
                    rd_data[gi] = '0;
                else if (we && rd_addr[gi] == WriteRegEff_W)
                    rd_data[gi] = Result_W;
            end
        end
    endgenerate

    assign RD1 = rd_data[0];
    assign RD2 = rd_data[1];

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed tables, corner sequences,
// and randomized traffic against a behavioural register-file model.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_W, MemtoReg_W, link_W, J_W, Jr_W, Retire_W;
    logic [1:0]  ByteControl_W;
    logic [31:0] ALU_result_W, ReadData_W, PC_plus_4_W;
    logic [4:0]  WriteReg_W, A1, A2;
    logic [31:0] RD1, RD2, Result_W, wr_count;
    logic [4:0]  WriteRegEff_W;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .RegWrite_W    (RegWrite_W),
        .MemtoReg_W    (MemtoReg_W),
        .link_W        (link_W),
        .J_W           (J_W),
        .Jr_W          (Jr_W),
        .ByteControl_W (ByteControl_W),
        .ALU_result_W  (ALU_result_W),
        .ReadData_W    (ReadData_W),
        .WriteReg_W    (WriteReg_W),
        .PC_plus_4_W   (PC_plus_4_W),
        .Retire_W      (Retire_W),
        .A1            (A1),
        .A2            (A2),
        .RD1           (RD1),
        .RD2           (RD2),
        .Result_W      (Result_W),
        .WriteRegEff_W (WriteRegEff_W),
        .wr_count      (wr_count)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] ref_regs [32];
    logic [31:0] ref_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference load: shift the wanted lane down, mask, then extend arithmetically.
    function automatic logic [31:0] m_load(input logic [1:0] bc, input logic [1:0] a,
                                           input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a)) & 32'h0000_00FF;
        h = (d >> (16 * a[1])) & 32'h0000_FFFF;
        case (bc)
            2'd0:    return d;
            2'd1:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            2'd2:    return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] m_result();
        if (link_W)     return PC_plus_4_W;
        if (MemtoReg_W) return m_load(ByteControl_W, ALU_result_W[1:0], ReadData_W);
        return ALU_result_W;
    endfunction

    function automatic logic [4:0] m_eff();
        return link_W ? 5'd31 : WriteReg_W;
    endfunction

    function automatic logic m_we();
        return RegWrite_W && (m_eff() != 5'd0);
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (rst || a == 5'd0)          return 32'd0;
        if (m_we() && a == m_eff())    return m_result();
        return ref_regs[a];
    endfunction

    // One transaction: compare all outputs before the edge, clock, update the model.
    task automatic txn(input string tag);
        logic [31:0] res;
        logic [4:0]  eff;
        logic        we;
        #1;
        res = m_result();
        eff = m_eff();
        we  = m_we();
        chk({tag, ".result"}, Result_W, res);
        chk({tag, ".eff"}, {27'd0, WriteRegEff_W}, {27'd0, eff});
        chk({tag, ".rd1"}, RD1, m_rd(A1));
        chk({tag, ".rd2"}, RD2, m_rd(A2));
        chk({tag, ".count"}, wr_count, ref_count);
        $display("txn %s rst=%0b we=%0b r%0d<=%08h cnt=%08h", tag, rst, we, eff, res, ref_count);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
            ref_count = 32'd0;
        end else begin
            if (we) ref_regs[eff] = res;
            if (we && Retire_W) ref_count = ref_count + 32'd1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        RegWrite_W = 0; MemtoReg_W = 0; link_W = 0; J_W = 0; Jr_W = 0; Retire_W = 0;
        ByteControl_W = 2'b00; ALU_result_W = 0; ReadData_W = 0; PC_plus_4_W = 0;
        WriteReg_W = 0; A1 = 0; A2 = 0;
    endtask

    typedef struct {
        logic [1:0]  bc;
        logic [1:0]  a;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t vecs [10];
    logic [31:0] saved_count;

    initial begin
        vecs[0] = '{2'b10, 2'd3, 32'hFFFF_FF80};
        vecs[1] = '{2'b11, 2'd2, 32'h0000_00FF};
        vecs[2] = '{2'b01, 2'd2, 32'hFFFF_80FF};
        vecs[3] = '{2'b00, 2'd0, 32'h80FF_7F01};
        vecs[4] = '{2'b00, 2'd3, 32'h80FF_7F01};
        vecs[5] = '{2'b10, 2'd1, 32'h0000_007F};
        vecs[6] = '{2'b10, 2'd2, 32'hFFFF_FFFF};
        vecs[7] = '{2'b01, 2'd0, 32'h0000_7F01};
        vecs[8] = '{2'b11, 2'd3, 32'h0000_0080};
        vecs[9] = '{2'b10, 2'd0, 32'h0000_0001};

        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        ref_count = 32'd0;
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        txn("reset0");
        rst = 0;

        // Write r5, then reset with a write to r6 presented at the same edge.
        RegWrite_W = 1; WriteReg_W = 5; ALU_result_W = 32'hDEAD_BEEF; Retire_W = 1; A1 = 5;
        txn("w_r5");
        rst = 1; WriteReg_W = 6; ALU_result_W = 32'h77; A2 = 6;
        txn("rst_w_r6");
        rst = 0; RegWrite_W = 0; Retire_W = 0;
        #1;
        chk("rst.rd1_r5", RD1, 32'd0);
        chk("rst.rd2_r6", RD2, 32'd0);
        chk("rst.count", wr_count, 32'd0);
        txn("post_rst");

        // ALU write with same-cycle bypass.
        RegWrite_W = 1; WriteReg_W = 8; ALU_result_W = 32'h1234_5678; Retire_W = 1; A1 = 8; A2 = 0;
        #1;
        chk("alu.bypass", RD1, 32'h1234_5678);
        txn("alu_r8");
        RegWrite_W = 0; Retire_W = 0;
        #1;
        chk("alu.stored", RD1, 32'h1234_5678);
        chk("alu.count", wr_count, 32'd1);
        txn("alu_read");

        // Load extraction table.
        MemtoReg_W = 1; RegWrite_W = 1; Retire_W = 1; WriteReg_W = 10; A1 = 10;
        ReadData_W = 32'h80FF_7F01;
        for (int i = 0; i < 10; i++) begin
            ByteControl_W = vecs[i].bc;
            ALU_result_W  = 32'h1000_0000 | {30'd0, vecs[i].a};
            #1;
            chk($sformatf("load%0d.result", i), Result_W, vecs[i].exp);
            chk($sformatf("load%0d.rd1", i), RD1, vecs[i].exp);
            txn($sformatf("load%0d", i));
        end
        MemtoReg_W = 0;

        // Link write overrides WriteReg_W=0.
        link_W = 1; WriteReg_W = 0; PC_plus_4_W = 32'h0040_0010; ALU_result_W = 32'hAAAA; A1 = 31;
        #1;
        chk("link.eff", {27'd0, WriteRegEff_W}, 32'd31);
        chk("link.bypass", RD1, 32'h0040_0010);
        txn("link");
        link_W = 0; RegWrite_W = 0; Retire_W = 0;
        #1;
        chk("link.stored", RD1, 32'h0040_0010);
        txn("link_read");

        // r0 protection.
        saved_count = ref_count;
        RegWrite_W = 1; WriteReg_W = 0; ALU_result_W = 32'h55; A1 = 0; Retire_W = 1;
        #1;
        chk("r0.rd1", RD1, 32'd0);
        txn("w_r0");
        #1;
        chk("r0.count", wr_count, saved_count);

        // Stall: same write held three cycles, retired only in the first.
        WriteReg_W = 3; ALU_result_W = 32'hA5A5; A1 = 3; Retire_W = 1;
        txn("stall0");
        Retire_W = 0;
        txn("stall1");
        txn("stall2");
        RegWrite_W = 0;
        #1;
        chk("stall.count", wr_count, saved_count + 32'd1);
        chk("stall.rd1", RD1, 32'hA5A5);

        // Counter wrap via backdoor preload.
        @(negedge clk);
        dut.wr_count_reg = 32'hFFFF_FFFF;
        ref_count = 32'hFFFF_FFFF;
        RegWrite_W = 1; WriteReg_W = 4; ALU_result_W = 32'h4444; Retire_W = 1; A1 = 4;
        txn("wrap");
        #1;
        chk("wrap.count", wr_count, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 39) == 0);
            RegWrite_W    = ($urandom_range(0, 3) != 0);
            MemtoReg_W    = $urandom_range(0, 1) == 1;
            link_W        = ($urandom_range(0, 7) == 0);
            J_W           = ($urandom_range(0, 7) == 0);
            Jr_W          = ($urandom_range(0, 7) == 0);
            Retire_W      = $urandom_range(0, 1) == 1;
            ByteControl_W = 2'($urandom_range(0, 3));
            ALU_result_W  = $urandom;
            ReadData_W    = $urandom;
            PC_plus_4_W   = $urandom;
            WriteReg_W    = 5'($urandom_range(0, 31));
            A1            = ($urandom_range(0, 3) == 0) ? m_eff() : 5'($urandom_range(0, 31));
            A2            = ($urandom_range(0, 3) == 0) ? m_eff() : 5'($urandom_range(0, 31));
            txn($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
